// File: rtl/store_verdict_monitor_if.sv
// Store-bus / log-port / verdict bundle between the processor side (master) and the monitor (slave).
interface store_verdict_monitor_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      adr;
  logic [31:0]      writedata;
  logic             memwrite;
  logic             log_rd;
  logic             log_valid;
  logic [31:0]      log_adr;
  logic [31:0]      log_data;
  logic             log_overflow;
  logic             done;
  logic             pass;
  logic             fail;
  logic             timeout;
  logic [15:0]      store_count;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output adr, writedata, memwrite, log_rd,
    input  log_valid, log_adr, log_data, log_overflow,
    input  done, pass, fail, timeout, store_count, cycle_count
  );

  modport slave (
    input  adr, writedata, memwrite, log_rd,
    output log_valid, log_adr, log_data, log_overflow,
    output done, pass, fail, timeout, store_count, cycle_count
  );
endinterface

// File: rtl/store_verdict_monitor.sv
// Store-bus monitor: logs every store in a FIFO and latches a sticky PASS/FAIL/TIMEOUT verdict.
// Optional macro STORE_DATA_CHECK_EN additionally requires writedata==PASS_DATA on the pass store.
module store_verdict_monitor #(
  parameter logic [31:0] PASS_ADR       = 32'd84,
  parameter logic [31:0] ALLOW_ADR      = 32'd80,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter int          CNT_W          = 16,
  parameter int          LOG_DEPTH      = 8
`ifdef STORE_DATA_CHECK_EN
  , parameter logic [31:0] PASS_DATA    = 32'd7
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  store_verdict_monitor_if.slave   bus
);
  localparam int               AW       = $clog2(LOG_DEPTH);
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]      OCC_FULL = (AW+1)'(LOG_DEPTH);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_e;

  state_e           state_q;
  logic             pass_q, fail_q, timeout_q;
  logic [15:0]      store_cnt_q;
  logic [CNT_W-1:0] cyc_cnt_q;

  logic store, adr_pass, adr_allow, data_ok;

  // memwrite of X/Z compares unknown and is therefore not a store
  assign store     = (state_q == S_RUN) && (bus.memwrite == 1'b1);
  assign adr_pass  = (bus.adr == PASS_ADR);
  assign adr_allow = (bus.adr == ALLOW_ADR);
`ifdef STORE_DATA_CHECK_EN
  assign data_ok   = (bus.writedata == PASS_DATA);
`else
  assign data_ok   = 1'b1;
`endif

  // Unknown compare results fall through the if-chain to FAIL
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      store_cnt_q <= '0;
      cyc_cnt_q   <= '0;
    end else if (state_q == S_RUN) begin
      if (store) begin
        if (store_cnt_q != 16'hFFFF) store_cnt_q <= store_cnt_q + 16'd1;
        if (adr_pass) begin
          if (data_ok) begin
            state_q <= S_PASS;
            pass_q  <= 1'b1;
          end else begin
            state_q <= S_FAIL;
            fail_q  <= 1'b1;
          end
        end else if (adr_allow) begin
          cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
        end else begin
          state_q <= S_FAIL;
          fail_q  <= 1'b1;
        end
      end else if (cyc_cnt_q >= CYC_LAST) begin
        state_q   <= S_TIMEOUT;
        timeout_q <= 1'b1;
      end else begin
        cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
      end
    end
  end

  // Store log FIFO, entry = {adr, writedata}
  logic [63:0]   mem_q [LOG_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   occ_q, occ_d;
  logic          ovf_q, full, valid, pop, push_ok;
  logic [63:0]   head;

  assign full    = (occ_q == OCC_FULL);
  assign valid   = (occ_q != '0);
  assign pop     = (bus.log_rd == 1'b1) && valid;
  assign push_ok = store && (!full || pop);

  always_comb begin
    occ_d = occ_q;
    if (push_ok && !pop)      occ_d = occ_q + (AW+1)'(1);
    else if (!push_ok && pop) occ_d = occ_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      occ_q <= occ_d;
      if (store && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {bus.adr, bus.writedata};
  end

  assign head             = mem_q[rd_ptr_q];
  assign bus.log_valid    = valid;
  assign bus.log_adr      = valid ? head[63:32] : 32'd0;
  assign bus.log_data     = valid ? head[31:0]  : 32'd0;
  assign bus.log_overflow = ovf_q;
  assign bus.pass         = pass_q;
  assign bus.fail         = fail_q;
  assign bus.timeout      = timeout_q;
  assign bus.done         = pass_q | fail_q | timeout_q;
  assign bus.store_count  = store_cnt_q;
  assign bus.cycle_count  = cyc_cnt_q;
endmodule

// File: tb/tb_store_verdict_monitor.sv
// Directed bench for store_verdict_monitor: verdicts, timeout boundary, log FIFO and mid-run reset.
module tb_store_verdict_monitor;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_verdict_monitor_if #(.CNT_W(16)) bus();

  store_verdict_monitor #(
    .TIMEOUT_CYCLES(16),
    .CNT_W(16),
    .LOG_DEPTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.memwrite = 1'b0;
    bus.log_rd   = 1'b0;
    step();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.adr       = a;
    bus.writedata = d;
    bus.memwrite  = 1'b1;
    bus.log_rd    = 1'b0;
    step();
    bus.memwrite  = 1'b0;
  endtask

  task automatic pop();
    bus.memwrite = 1'b0;
    bus.log_rd   = 1'b1;
    step();
    bus.log_rd   = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.memwrite = 1'b0;
    bus.log_rd   = 1'b0;
    step();
    reset        = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.done !== 1'b0)           begin errors++; $display("FAIL rst_done: got %0b want 0", bus.done); end
    checks++; if ({bus.pass, bus.fail, bus.timeout} !== 3'b000) begin errors++; $display("FAIL rst_verdict: got %b want 000", {bus.pass, bus.fail, bus.timeout}); end
    checks++; if (bus.log_valid !== 1'b0)      begin errors++; $display("FAIL rst_valid: got %0b want 0", bus.log_valid); end
    checks++; if (bus.log_adr !== 32'd0)       begin errors++; $display("FAIL rst_log_adr: got %0h want 0", bus.log_adr); end
    checks++; if (bus.store_count !== 16'd0)   begin errors++; $display("FAIL rst_store_count: got %0d want 0", bus.store_count); end
    checks++; if (bus.cycle_count !== 16'd0)   begin errors++; $display("FAIL rst_cycle_count: got %0d want 0", bus.cycle_count); end
    checks++; if (bus.log_overflow !== 1'b0)   begin errors++; $display("FAIL rst_overflow: got %0b want 0", bus.log_overflow); end
    pop();
    checks++; if (bus.log_valid !== 1'b0)      begin errors++; $display("FAIL empty_pop_valid: got %0b want 0", bus.log_valid); end
  endtask

  task automatic test_pass();
    do_reset();
    idle(); idle();
    store(32'd80, 32'd5);
    checks++; if (bus.log_valid !== 1'b1)      begin errors++; $display("FAIL push_valid: got %0b want 1", bus.log_valid); end
    checks++; if (bus.done !== 1'b0)           begin errors++; $display("FAIL allow_done: got %0b want 0", bus.done); end
    idle(); idle();
    store(32'd84, 32'd7);
    checks++; if (bus.pass !== 1'b1)           begin errors++; $display("FAIL pass_pass: got %0b want 1", bus.pass); end
    checks++; if (bus.fail !== 1'b0)           begin errors++; $display("FAIL pass_fail: got %0b want 0", bus.fail); end
    checks++; if (bus.done !== 1'b1)           begin errors++; $display("FAIL pass_done: got %0b want 1", bus.done); end
    checks++; if (bus.store_count !== 16'd2)   begin errors++; $display("FAIL pass_store_count: got %0d want 2", bus.store_count); end
    checks++; if (bus.log_adr !== 32'd80 || bus.log_data !== 32'd5) begin errors++; $display("FAIL pass_head0: got %0d/%0d want 80/5", bus.log_adr, bus.log_data); end
    pop();
    checks++; if (bus.log_adr !== 32'd84 || bus.log_data !== 32'd7) begin errors++; $display("FAIL pass_head1: got %0d/%0d want 84/7", bus.log_adr, bus.log_data); end
    pop();
    checks++; if (bus.log_valid !== 1'b0 || bus.log_data !== 32'd0) begin errors++; $display("FAIL pass_drained: got %0b/%0d want 0/0", bus.log_valid, bus.log_data); end
  endtask

  task automatic test_fail();
    do_reset();
    store(32'd88, 32'd3);
    checks++; if (bus.fail !== 1'b1 || bus.done !== 1'b1) begin errors++; $display("FAIL fail_verdict: got fail=%0b done=%0b want 1/1", bus.fail, bus.done); end
    store(32'd84, 32'd7);
    checks++; if (bus.pass !== 1'b0)           begin errors++; $display("FAIL fail_sticky_pass: got %0b want 0", bus.pass); end
    checks++; if (bus.store_count !== 16'd1)   begin errors++; $display("FAIL fail_store_count: got %0d want 1", bus.store_count); end
    checks++; if (bus.log_adr !== 32'd88)      begin errors++; $display("FAIL fail_head: got %0d want 88", bus.log_adr); end
    pop();
    checks++; if (bus.log_valid !== 1'b0)      begin errors++; $display("FAIL fail_no_late_push: got %0b want 0", bus.log_valid); end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (15) idle();
    checks++; if (bus.timeout !== 1'b0 || bus.cycle_count !== 16'd15) begin errors++; $display("FAIL to_pre: got to=%0b cnt=%0d want 0/15", bus.timeout, bus.cycle_count); end
    idle();
    checks++; if (bus.timeout !== 1'b1 || bus.done !== 1'b1) begin errors++; $display("FAIL to_verdict: got to=%0b done=%0b want 1/1", bus.timeout, bus.done); end
    checks++; if (bus.cycle_count !== 16'd15)  begin errors++; $display("FAIL to_count: got %0d want 15", bus.cycle_count); end
    repeat (3) idle();
    checks++; if (bus.cycle_count !== 16'd15 || bus.pass !== 1'b0) begin errors++; $display("FAIL to_frozen: got cnt=%0d pass=%0b want 15/0", bus.cycle_count, bus.pass); end
    do_reset();
    repeat (15) idle();
    store(32'd84, 32'd7);
    checks++; if (bus.pass !== 1'b1 || bus.timeout !== 1'b0) begin errors++; $display("FAIL to_store_wins: got pass=%0b to=%0b want 1/0", bus.pass, bus.timeout); end
    checks++; if (bus.cycle_count !== 16'd15)  begin errors++; $display("FAIL to_store_count: got %0d want 15", bus.cycle_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) store(32'd80, i);
    checks++; if (bus.log_overflow !== 1'b0 || bus.store_count !== 16'd8) begin errors++; $display("FAIL full_state: got ovf=%0b cnt=%0d want 0/8", bus.log_overflow, bus.store_count); end
    bus.adr = 32'd80; bus.writedata = 32'd8; bus.memwrite = 1'b1; bus.log_rd = 1'b1;
    step();
    bus.memwrite = 1'b0; bus.log_rd = 1'b0;
    checks++; if (bus.log_overflow !== 1'b0)   begin errors++; $display("FAIL full_pushpop_ovf: got %0b want 0", bus.log_overflow); end
    store(32'd80, 32'd9);
    checks++; if (bus.log_overflow !== 1'b1)   begin errors++; $display("FAIL full_drop_ovf: got %0b want 1", bus.log_overflow); end
    checks++; if (bus.store_count !== 16'd10)  begin errors++; $display("FAIL full_store_count: got %0d want 10", bus.store_count); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (bus.log_valid !== 1'b1 || bus.log_data !== i) begin errors++; $display("FAIL full_drain_%0d: got v=%0b d=%0d want 1/%0d", i, bus.log_valid, bus.log_data, i); end
      pop();
    end
    checks++; if (bus.log_valid !== 1'b0)      begin errors++; $display("FAIL full_empty: got %0b want 0", bus.log_valid); end
    checks++; if (bus.log_overflow !== 1'b1)   begin errors++; $display("FAIL full_ovf_sticky: got %0b want 1", bus.log_overflow); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) store(32'd80, 32'd1);
    reset = 1'b1;
    step();
    checks++; if ({bus.done, bus.pass, bus.fail, bus.timeout, bus.log_valid, bus.log_overflow} !== 6'd0) begin errors++; $display("FAIL mid_rst_flags: got %b want 000000", {bus.done, bus.pass, bus.fail, bus.timeout, bus.log_valid, bus.log_overflow}); end
    checks++; if (bus.store_count !== 16'd0 || bus.cycle_count !== 16'd0) begin errors++; $display("FAIL mid_rst_counts: got %0d/%0d want 0/0", bus.store_count, bus.cycle_count); end
    reset = 1'b0;
    store(32'd84, 32'd7);
    checks++; if (bus.pass !== 1'b1 || bus.store_count !== 16'd1) begin errors++; $display("FAIL mid_rst_pass: got pass=%0b cnt=%0d want 1/1", bus.pass, bus.store_count); end
    checks++; if (bus.log_adr !== 32'd84)      begin errors++; $display("FAIL mid_rst_head: got %0d want 84", bus.log_adr); end
  endtask

  task automatic test_data_check();
    do_reset();
    store(32'd84, 32'd6);
`ifdef STORE_DATA_CHECK_EN
    checks++; if (bus.fail !== 1'b1 || bus.pass !== 1'b0) begin errors++; $display("FAIL data_bad: got pass=%0b fail=%0b want 0/1", bus.pass, bus.fail); end
`else
    checks++; if (bus.pass !== 1'b1 || bus.fail !== 1'b0) begin errors++; $display("FAIL data_ignored: got pass=%0b fail=%0b want 1/0", bus.pass, bus.fail); end
`endif
    do_reset();
    store(32'd80, 32'd99);
    store(32'd84, 32'd7);
    checks++; if (bus.pass !== 1'b1 || bus.fail !== 1'b0) begin errors++; $display("FAIL data_good: got pass=%0b fail=%0b want 1/0", bus.pass, bus.fail); end
  endtask

  initial begin
    reset         = 1'b1;
    bus.adr       = 32'd0;
    bus.writedata = 32'd0;
    bus.memwrite  = 1'b0;
    bus.log_rd    = 1'b0;
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_overflow();
    test_mid_reset();
    test_data_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_verdict_monitor.md
Name: store_verdict_monitor

Overview:
- Synthesizable store-bus monitor directly downstream of the multi-cycle MIPS top (TOP_M).
- Consumes the processor's data-memory write port (adr, writedata, memwrite) and logs every store in a small FIFO.
- Produces a sticky pass/fail/timeout verdict, so self-check runs on FPGA without a simulator and bench checks reduce to polling done/pass.

Parameters:
- PASS_ADR, 32'd84, store address that signals program success.
- ALLOW_ADR, 32'd80, only other store address permitted before success.
- TIMEOUT_CYCLES, 4096, cycles after reset release with no verdict before TIMEOUT; must be >= 2.
- CNT_W, 16, width of cycle_count; TIMEOUT_CYCLES must be < 2**CNT_W.
- LOG_DEPTH, 8, store-log FIFO depth; power of two, >= 2.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous active-high reset.
- adr, input, 32, processor memory address.
- writedata, input, 32, processor store data.
- memwrite, input, 1, processor store strobe; one store per asserted cycle.
- log_rd, input, 1, pop the store-log head.
- log_valid, output, 1, log non-empty.
- log_adr, output, 32, head entry address (first-word-fall-through).
- log_data, output, 32, head entry data.
- log_overflow, output, 1, sticky: a store was dropped because the log was full.
- done, output, 1, verdict reached (state != RUN).
- pass, output, 1, verdict PASS.
- fail, output, 1, verdict FAIL.
- timeout, output, 1, verdict TIMEOUT.
- store_count, output, 16, stores seen in RUN; saturates at 16'hFFFF.
- cycle_count, output, CNT_W, cycles spent in RUN since reset; freezes at the verdict.

Behaviour:
- Reset (sync, high):
  - State goes to RUN.
  - All outputs 0; FIFO emptied; counters 0.
  - Reset asserted mid-operation aborts the verdict and the log in that same edge.
- States RUN, PASS, FAIL, TIMEOUT. The verdict outputs are registered and one-hot; done = pass|fail|timeout.
- A store event is memwrite==1 while the state is RUN. Any other value of memwrite (0, X, Z) is not a store.
- RUN transitions, in priority order:
  - store with adr==PASS_ADR -> PASS.
  - store with adr==ALLOW_ADR -> stay in RUN.
  - store to any other adr, including unknown bits -> FAIL.
  - no store and cycle_count==TIMEOUT_CYCLES-1 -> TIMEOUT.
  - A store on the timeout cycle wins over timeout.
- PASS, FAIL and TIMEOUT are terminal until reset. Later stores are ignored: no log push, no count change.
- Verdict latency: a store sampled at edge N sets pass or fail visible after edge N.
- cycle_count increments every RUN cycle. A clean program therefore times out with cycle_count==TIMEOUT_CYCLES-1 frozen.
- store_count increments for every store event, including the terminating one.
- Log FIFO entry format: {adr, writedata}.
  - Push on every store event, including the terminating one.
  - Head is presented combinationally; log_adr and log_data hold 0 when empty.
  - Pop when log_rd && log_valid; log_rd while empty is ignored.
  - Push while full without a same-cycle pop: entry dropped, log_overflow set (sticky).
  - Push and pop together while full: both happen, occupancy unchanged, no overflow.
  - Push while empty: log_valid rises the next cycle (no bypass).
  - Read/write pointers wrap modulo LOG_DEPTH; occupancy counter width is clog2(LOG_DEPTH)+1.
- The log stays readable in terminal states, so pops continue after the verdict.

Optional Feature:
- Macro: STORE_DATA_CHECK_EN.
- Defined: adds parameter PASS_DATA (default 32'd7). A store to PASS_ADR gives PASS only if writedata==PASS_DATA; otherwise it gives FAIL. A store to ALLOW_ADR stays in RUN regardless of data.
- Undefined: writedata only feeds the log and is not compared.

Test Plan:
- Reset 1 cycle; store adr=80 data=5 at cycle 3, then adr=84 data=7 at cycle 6 -> pass=1 after the cycle-6 edge, fail=0, store_count=2, log pops (80,5) then (84,7), then log_valid=0.
- Store adr=88 -> fail=1 next edge, done=1; a following store to 84 leaves pass=0 and store_count=1.
- TIMEOUT_CYCLES=16, no stores -> timeout=1 after the 16th RUN edge, cycle_count=15 and frozen; a store on cycle 15 to 84 instead gives pass=1, timeout=0.
- LOG_DEPTH=8, ten stores to 80 with no pops -> 8 entries, log_overflow=1, store_count=10; push+pop in the same cycle while full keeps 8 entries with no further drop.
- Reset asserted mid-run after 3 stores -> next edge: all outputs 0, log_valid=0, state RUN; a new store to 84 passes.
- With STORE_DATA_CHECK_EN: store adr=84 data=6 -> fail=1; data=7 -> pass=1.
